// File: rtl/sdram_wb_prefetch_arb.sv
// Round-robin Wishbone arbiter in front of an SDRAM controller, with a single
// write-through prefetch line that serves read hits without a controller access.
module sdram_wb_prefetch_arb #(
  parameter int NUM_M    = 2,
  parameter int ADDR_W   = 23,
  parameter int PF_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M-1:0]         m_cyc,
  input  logic [NUM_M-1:0]         m_stb,
  input  logic [NUM_M-1:0]         m_we,
  input  logic [4*NUM_M-1:0]       m_sel,
  input  logic [ADDR_W*NUM_M-1:0]  m_adr,
  input  logic [32*NUM_M-1:0]      m_wdat,
  output logic [NUM_M-1:0]         m_ack,
  output logic [31:0]              m_rdat,
  output logic [ADDR_W-1:0]        c_addr,
  output logic                     c_rw,
  output logic [31:0]              c_wdata,
  output logic [3:0]               c_mask,
  output logic                     c_in_valid,
  input  logic                     c_busy,
  input  logic [31:0]              c_rdata,
  input  logic                     c_out_valid,
  input  logic                     inv,
  output logic [15:0]              hit_cnt,
  output logic [15:0]              miss_cnt
);

  localparam int LW = $clog2(PF_DEPTH);
  localparam int TW = ADDR_W - LW;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_HIT, S_WRITE, S_FILL, S_WAIT, S_RESP
  } state_t;

  state_t              r_state, w_state_nx;
  logic [1:0]          r_rr, r_gnt;
  logic [ADDR_W-1:0]   r_adr;
  logic [3:0]          r_sel;
  logic [31:0]         r_wdat;
  logic [LW-1:0]       r_fidx;
  logic [TW-1:0]       r_tag;
  logic                r_valid;
  logic                r_inv_pend;
  logic [31:0]         r_rdat;
  logic [15:0]         r_hit_cnt, r_miss_cnt;
  logic [31:0]         r_line [PF_DEPTH];

  logic [NUM_M-1:0]    w_req;
  logic [3:0]          w_req4;
  logic                w_found;
  logic [1:0]          w_pick;
  logic [ADDR_W-1:0]   w_adr;
  logic                w_we;
  logic [3:0]          w_sel;
  logic [31:0]         w_wdat;
  logic                w_hit;
  logic                w_last;
  logic                w_wr_hit;
  logic [LW-1:0]       w_rword;
  logic [1:0]          w_rr_nx;

  assign w_req    = m_cyc & m_stb;
  assign w_rword  = r_adr[LW-1:0];
  assign w_last   = (r_fidx == LW'(PF_DEPTH - 1));
  assign w_rr_nx  = (r_gnt == 2'(NUM_M - 1)) ? 2'd0 : r_gnt + 2'd1;
  assign w_wr_hit = r_valid && (r_tag == r_adr[ADDR_W-1:LW]);

  // Round-robin search starting at r_rr, wrapping at NUM_M (not a power of two in general).
  always_comb begin
    int unsigned idx;
    w_req4              = '0;
    w_req4[NUM_M-1:0]   = w_req;
    w_found             = 1'b0;
    w_pick              = r_rr;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      idx = 32'(r_rr) + k;
      if (idx >= NUM_M) idx = idx - NUM_M;
      if (!w_found && w_req4[idx[1:0]]) begin
        w_found = 1'b1;
        w_pick  = idx[1:0];
      end
    end
  end

  always_comb begin
    w_adr  = '0;
    w_we   = 1'b0;
    w_sel  = '0;
    w_wdat = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      if (w_pick == k[1:0]) begin
        w_adr  = m_adr[k*ADDR_W +: ADDR_W];
        w_we   = m_we[k];
        w_sel  = m_sel[k*4 +: 4];
        w_wdat = m_wdat[k*32 +: 32];
      end
    end
  end

  assign w_hit = r_valid && (r_tag == w_adr[ADDR_W-1:LW]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (|w_req) w_state_nx = S_ARB;
      S_ARB: begin
        if (!w_found)   w_state_nx = S_IDLE;
        else if (w_we)  w_state_nx = S_WRITE;
        else if (w_hit) w_state_nx = S_HIT;
        else            w_state_nx = S_FILL;
      end
      S_HIT:   w_state_nx = S_RESP;
      S_WRITE: if (!c_busy) w_state_nx = S_RESP;
      S_FILL:  if (!c_busy) w_state_nx = S_WAIT;
      S_WAIT:  if (c_out_valid) w_state_nx = w_last ? S_RESP : S_FILL;
      S_RESP:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr       <= '0;
      r_gnt      <= '0;
      r_adr      <= '0;
      r_sel      <= '0;
      r_wdat     <= '0;
      r_fidx     <= '0;
      r_tag      <= '0;
      r_valid    <= 1'b0;
      r_inv_pend <= 1'b0;
      r_rdat     <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      unique case (r_state)
        S_ARB: if (w_found) begin
          r_gnt  <= w_pick;
          r_adr  <= w_adr;
          r_sel  <= w_sel;
          r_wdat <= w_wdat;
          if (!w_we) begin
            if (w_hit) begin
              if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
              if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 16'd1;
              r_valid    <= 1'b0;
              r_inv_pend <= 1'b0;
              r_fidx     <= '0;
            end
          end
        end
        S_HIT: r_rdat <= r_line[w_rword];
        S_WAIT: if (c_out_valid) begin
          if (w_last) begin
            r_tag   <= r_adr[ADDR_W-1:LW];
            r_valid <= !(r_inv_pend || inv);
            r_rdat  <= (w_rword == r_fidx) ? c_rdata : r_line[w_rword];
          end else begin
            r_fidx <= r_fidx + LW'(1);
          end
        end
        S_RESP: r_rr <= w_rr_nx;
        default: ;
      endcase
      // An invalidate during a fill is deferred so the in-flight read still completes.
      if (inv) begin
        if (r_state == S_FILL || r_state == S_WAIT) r_inv_pend <= 1'b1;
        else                                         r_valid    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_WAIT && c_out_valid) begin
        r_line[r_fidx] <= c_rdata;
      end else if (r_state == S_WRITE && !c_busy && w_wr_hit) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (r_sel[b]) r_line[w_rword][b*8 +: 8] <= r_wdat[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_M; k++) begin
      m_ack[k] = (r_state == S_RESP) && (r_gnt == k[1:0]);
    end
  end

  assign m_rdat     = r_rdat;
  assign c_in_valid = (r_state == S_WRITE || r_state == S_FILL) && !c_busy;
  assign c_rw       = (r_state == S_WRITE);
  assign c_addr     = (r_state == S_FILL) ? {r_adr[ADDR_W-1:LW], r_fidx} : r_adr;
  assign c_wdata    = r_wdat;
  assign c_mask     = r_sel;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_sdram_wb_prefetch_arb.sv
// Directed + randomized bench for sdram_wb_prefetch_arb with a behavioural
// SDRAM controller and a line/arbiter reference model.
module tb_sdram_wb_prefetch_arb;
  localparam int NUM_M  = 2;
  localparam int ADDR_W = 23;
  localparam int PF     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [NUM_M-1:0]        m_cyc, m_stb, m_we, m_ack;
  logic [4*NUM_M-1:0]      m_sel;
  logic [ADDR_W*NUM_M-1:0] m_adr;
  logic [32*NUM_M-1:0]     m_wdat;
  logic [31:0]             m_rdat, c_wdata, c_rdata;
  logic [ADDR_W-1:0]       c_addr;
  logic                    c_rw, c_in_valid, c_busy, c_out_valid, inv;
  logic [3:0]              c_mask;
  logic [15:0]             hit_cnt, miss_cnt;

  logic        ctl_ov, man_ov, ctl_hold;
  logic [31:0] ctl_rd, man_rd;
  assign c_out_valid = ctl_ov | man_ov;
  assign c_rdata     = man_ov ? man_rd : ctl_rd;

  sdram_wb_prefetch_arb #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .PF_DEPTH(PF)) dut (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_sel(m_sel), .m_adr(m_adr), .m_wdat(m_wdat), .m_ack(m_ack), .m_rdat(m_rdat),
    .c_addr(c_addr), .c_rw(c_rw), .c_wdata(c_wdata), .c_mask(c_mask),
    .c_in_valid(c_in_valid), .c_busy(c_busy), .c_rdata(c_rdata),
    .c_out_valid(c_out_valid), .inv(inv), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_init(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  // Controller-side memory and the bench's own expectation of memory contents.
  logic [31:0] ctl_mem [int];
  logic [31:0] exp_mem [int];

  function automatic logic [31:0] exp_word(input int a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return mem_init(a);
  endfunction

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        mask;
  } cmd_t;
  cmd_t cmd_q[$];

  // Reference model: one line (valid/tag), round-robin pointer, counters.
  bit ref_valid;
  int ref_tag, ref_rr, ref_hits, ref_miss;

  function automatic bit ref_read(input int a);
    bit h;
    h = ref_valid && (ref_tag == a / PF);
    if (h) ref_hits++;
    else begin
      ref_miss++;
      ref_valid = 1'b1;
      ref_tag   = a / PF;
    end
    return h;
  endfunction

  // Behavioural controller: one read outstanding, random latency and busy stalls.
  initial begin : controller
    bit          got, pend;
    cmd_t        g;
    int          cnt;
    logic [ADDR_W-1:0] p_addr;
    logic [31:0] w;
    c_busy = 1'b0; ctl_ov = 1'b0; ctl_rd = '0;
    pend = 1'b0; cnt = 0; p_addr = '0;
    forever begin
      @(negedge clk);
      got = c_in_valid;
      g.rw = c_rw; g.addr = c_addr; g.wdata = c_wdata; g.mask = c_mask;
      if (got) chk("cmd_gate_busy_outstanding", {30'd0, pend, c_busy}, 32'd0);
      @(posedge clk);
      #1;
      ctl_ov = 1'b0;
      if (rst) begin
        pend = 1'b0; c_busy = 1'b0;
      end else if (got) begin
        cmd_q.push_back(g);
        if (g.rw) begin
          w = ctl_mem.exists(int'(g.addr)) ? ctl_mem[int'(g.addr)] : mem_init(int'(g.addr));
          for (int b = 0; b < 4; b++) if (g.mask[b]) w[b*8 +: 8] = g.wdata[b*8 +: 8];
          ctl_mem[int'(g.addr)] = w;
          c_busy = ($urandom % 3 == 0);
        end else begin
          pend = 1'b1; p_addr = g.addr; cnt = $urandom_range(0, 3); c_busy = 1'b1;
        end
      end else if (pend) begin
        if (!ctl_hold) begin
          if (cnt == 0) begin
            ctl_ov = 1'b1;
            ctl_rd = ctl_mem.exists(int'(p_addr)) ? ctl_mem[int'(p_addr)] : mem_init(int'(p_addr));
            pend = 1'b0;
            c_busy = ($urandom % 4 == 0);
          end else cnt--;
        end
      end else begin
        c_busy = ($urandom % 4 == 0);
      end
    end
  end

  task automatic txn(input int m, input bit we, input logic [ADDR_W-1:0] a,
                     input logic [3:0] sel, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat);
    logic [NUM_M-1:0] e;
    @(negedge clk);
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_sel[m*4 +: 4] = sel; m_adr[m*ADDR_W +: ADDR_W] = a; m_wdat[m*32 +: 32] = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (m_ack == '0 && lat < 200);
    e = '0; e[m] = 1'b1;
    chk("ack_owner", 32'(m_ack), 32'(e));
    rd = m_rdat;
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
  endtask

  task automatic do_read(input int m, input int a, input string tag);
    logic [31:0] rd;
    int lat;
    bit h;
    h = ref_read(a);
    cmd_q.delete();
    txn(m, 1'b0, ADDR_W'(a), 4'h0, 32'h0, rd, lat);
    chk({tag, "_data"}, rd, exp_word(a));
    chk({tag, "_ncmd"}, 32'(cmd_q.size()), h ? 32'd0 : 32'(PF));
    if (!h) begin
      for (int i = 0; i < PF && i < cmd_q.size(); i++)
        chk({tag, "_fill_cmd"}, {8'd0, cmd_q[i].rw, cmd_q[i].addr}, 32'((a / PF) * PF + i));
    end else begin
      chk({tag, "_hit_latency"}, 32'(lat), 32'd3);
    end
    ref_rr = (m + 1) % NUM_M;
    chk({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(ref_hits));
    chk({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(ref_miss));
  endtask

  task automatic do_write(input int m, input int a, input logic [3:0] sel,
                          input logic [31:0] wd, input string tag);
    logic [31:0] rd, prev, nw;
    int lat;
    prev = m_rdat;
    cmd_q.delete();
    txn(m, 1'b1, ADDR_W'(a), sel, wd, rd, lat);
    chk({tag, "_ncmd"}, 32'(cmd_q.size()), 32'd1);
    if (cmd_q.size() >= 1) begin
      chk({tag, "_cmd_rw_addr"}, {8'd0, cmd_q[0].rw, cmd_q[0].addr}, 32'(a) | 32'h0080_0000);
      chk({tag, "_cmd_wdata"}, cmd_q[0].wdata, wd);
      chk({tag, "_cmd_mask"}, 32'(cmd_q[0].mask), 32'(sel));
    end
    chk({tag, "_rdat_hold"}, rd, prev);
    nw = exp_word(a);
    for (int b = 0; b < 4; b++) if (sel[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
    exp_mem[a] = nw;
    ref_rr = (m + 1) % NUM_M;
    chk({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(ref_hits));
    chk({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(ref_miss));
  endtask

  // Masters 0 and 1 request reads in the same cycle.
  task automatic contend(input int a0, input int a1, input string tag, output logic [31:0] d_m0);
    int ord [2];
    logic [31:0] dat [2];
    int n, cyc, e0, e1, ncmd;
    bit h0, h1;
    ord[0] = 9; ord[1] = 9; dat[0] = '0; dat[1] = '0; n = 0; cyc = 0;
    e0 = (ref_rr == 1) ? 1 : 0;
    e1 = 1 - e0;
    cmd_q.delete();
    @(negedge clk);
    m_we[1:0] = 2'b00;
    m_adr[0 +: ADDR_W] = ADDR_W'(a0); m_adr[ADDR_W +: ADDR_W] = ADDR_W'(a1);
    m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11;
    while (n < 2 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (m_ack != '0) begin
        ord[n] = m_ack[0] ? 0 : 1;
        dat[n] = m_rdat;
        m_cyc[ord[n]] = 1'b0; m_stb[ord[n]] = 1'b0;
        n++;
      end
    end
    m_cyc[1:0] = 2'b00; m_stb[1:0] = 2'b00;
    chk({tag, "_nacks"}, 32'(n), 32'd2);
    chk({tag, "_first"}, 32'(ord[0]), 32'(e0));
    chk({tag, "_second"}, 32'(ord[1]), 32'(e1));
    h0 = ref_read(e0 == 0 ? a0 : a1);
    h1 = ref_read(e1 == 0 ? a0 : a1);
    chk({tag, "_data_first"}, dat[0], exp_word(e0 == 0 ? a0 : a1));
    chk({tag, "_data_second"}, dat[1], exp_word(e1 == 0 ? a0 : a1));
    ncmd = (h0 ? 0 : PF) + (h1 ? 0 : PF);
    chk({tag, "_ncmd"}, 32'(cmd_q.size()), 32'(ncmd));
    ref_rr = (e1 + 1) % NUM_M;
    chk({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(ref_hits));
    chk({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(ref_miss));
    d_m0 = (ord[0] == 0) ? dat[0] : dat[1];
  endtask

  initial begin : main
    logic [31:0] d0, old6;
    int k;
    bit any;
    rst = 1'b1; inv = 1'b0; man_ov = 1'b0; man_rd = '0; ctl_hold = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_wdat = '0;
    ref_valid = 1'b0; ref_tag = 0; ref_rr = 0; ref_hits = 0; ref_miss = 0;
    repeat (3) @(negedge clk);
    chk("rst_m_ack", 32'(m_ack), 32'd0);
    chk("rst_c_in_valid", 32'(c_in_valid), 32'd0);
    chk("rst_c_rw", 32'(c_rw), 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_m_rdat", m_rdat, 32'd0);
    rst = 1'b0;

    do_read(0, 5, "cold_read");
    do_read(0, 6, "hit_read");
    do_write(1, 6, 4'b0011, 32'hDEADBEEF, "wt_write");
    contend(6, 7, "contend_a", d0);
    old6 = mem_init(6);
    chk("wt_merged_word", d0, {old6[31:16], 16'hBEEF});
    contend(4, 5, "contend_b", d0);

    for (int i = 0; i < 40; i++) begin
      int m, a;
      m = $urandom_range(0, NUM_M - 1);
      a = $urandom_range(0, 15);
      if ($urandom % 3 == 0) do_write(m, a, 4'($urandom_range(1, 15)), $urandom, "rnd_write");
      else                   do_read(m, a, "rnd_read");
      if ($urandom % 8 == 0) begin
        @(negedge clk); inv = 1'b1;
        @(negedge clk); inv = 1'b0;
        ref_valid = 1'b0;
      end
    end

    fork
      do_read(0, 32'h21, "inv_fill");
      begin
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!c_in_valid && k < 100);
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
      end
    join
    ref_valid = 1'b0;
    do_read(1, 32'h22, "after_inv");

    ctl_hold = 1'b1;
    cmd_q.delete();
    @(negedge clk);
    m_we[0] = 1'b0; m_adr[0 +: ADDR_W] = ADDR_W'(32'h45); m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (cmd_q.size() == 0 && k < 100);
    chk("rstwait_fill_started", 32'(cmd_q.size()), 32'd1);
    rst = 1'b1; m_cyc = '0; m_stb = '0;
    @(negedge clk);
    chk("rstwait_m_ack", 32'(m_ack), 32'd0);
    chk("rstwait_c_in_valid", 32'(c_in_valid), 32'd0);
    chk("rstwait_c_rw", 32'(c_rw), 32'd0);
    chk("rstwait_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rstwait_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rstwait_m_rdat", m_rdat, 32'd0);
    rst = 1'b0; ctl_hold = 1'b0;
    man_rd = 32'h1234_5678; man_ov = 1'b1;
    @(negedge clk);
    man_ov = 1'b0;
    any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m_ack != '0 || c_in_valid) any = 1'b1;
    end
    chk("late_ov_no_ack", 32'(any), 32'd0);
    chk("late_ov_rdat", m_rdat, 32'd0);
    ref_valid = 1'b0; ref_rr = 0; ref_hits = 0; ref_miss = 0;
    do_read(0, 32'h46, "post_rst_read");
    do_read(1, 32'h47, "post_rst_hit");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
